// File: rtl/exec_unit.sv
// Execute stage behind the 8x16 register file: eight ALU ops, with a
// multi-cycle shift-add multiply, driving the file's write port with registered results.
module exec_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] r_in,
  input  logic [15:0] s_in,
  input  logic [2:0]  dst_adr,
  output logic        busy,
  output logic [15:0] w,
  output logic [2:0]  w_adr,
  output logic        we,
  output logic        zero,
  output logic        carry
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [2:0]  dst_q, dst_d;
  logic [15:0] w_q, w_d;
  logic [2:0]  w_adr_q, w_adr_d;
  logic        we_q, we_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;

  logic [16:0] alu_res;
  logic [31:0] mcand_ext, pp0, pp1, acc_step, acc_fin;
  logic [4:0]  cnt_p1;

  // Bit 16 carries the carry/borrow; logic and shift ops leave it clear.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = {1'b0, r_in} + {1'b0, s_in};
      OP_SUB:  alu_res = {1'b0, r_in} - {1'b0, s_in};
      OP_AND:  alu_res = {1'b0, r_in & s_in};
      OP_OR:   alu_res = {1'b0, r_in | s_in};
      OP_XOR:  alu_res = {1'b0, r_in ^ s_in};
      OP_SHL:  alu_res = {1'b0, r_in << s_in[3:0]};
      OP_SHR:  alu_res = {1'b0, r_in >> s_in[3:0]};
      default: alu_res = '0;
    endcase
  end

  // The final cycle folds the last two partial products together so the
  // write lands in the 16th cycle after accept while busy spans only 15.
  always_comb begin
    mcand_ext = {16'h0000, mcand_q};
    cnt_p1    = {1'b0, cnt_q} + 5'd1;
    pp0       = mplier_q[0] ? (mcand_ext << cnt_q)  : 32'h0;
    pp1       = mplier_q[1] ? (mcand_ext << cnt_p1) : 32'h0;
    acc_step  = acc_q + pp0;
    acc_fin   = acc_step + pp1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    dst_d    = dst_q;
    w_d      = w_q;
    w_adr_d  = w_adr_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    we_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = r_in;
            mplier_d = s_in;
            dst_d    = dst_adr;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            w_d     = alu_res[15:0];
            carry_d = alu_res[16];
            zero_d  = (alu_res[15:0] == 16'h0000);
            w_adr_d = dst_adr;
            we_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == 4'd14) begin
          acc_d   = acc_fin;
          w_d     = acc_fin[15:0];
          carry_d = |acc_fin[31:16];
          zero_d  = (acc_fin[15:0] == 16'h0000);
          w_adr_d = dst_q;
          we_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_step;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      dst_q    <= '0;
      w_q      <= '0;
      w_adr_q  <= '0;
      we_q     <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      dst_q    <= dst_d;
      w_q      <= w_d;
      w_adr_q  <= w_adr_d;
      we_q     <= we_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign busy  = (state_q == S_MUL);
  assign w     = w_q;
  assign w_adr = w_adr_q;
  assign we    = we_q;
  assign zero  = zero_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: stimulus pushes expected writes, a
// negedge monitor pops and compares whenever we is high.
module tb_exec_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] r_in = '0;
  logic [15:0] s_in = '0;
  logic [2:0]  dst_adr = '0;
  logic        busy, we, zero, carry;
  logic [15:0] w;
  logic [2:0]  w_adr;

  typedef struct {
    logic [15:0] w;
    logic [2:0]  adr;
    logic        z;
    logic        c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int exp_cnt = 0;

  exec_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .r_in(r_in),
    .s_in(s_in), .dst_adr(dst_adr), .busy(busy), .w(w), .w_adr(w_adr),
    .we(we), .zero(zero), .carry(carry)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] ew, input logic [2:0] ea, input logic ez, input logic ec);
    exp_t e;
    e.w = ew; e.adr = ea; e.z = ez; e.c = ec;
    sb.push_back(e);
    exp_cnt++;
  endtask

  // Presents one request for a single cycle; caller decides whether start drops.
  task automatic drive(input logic [2:0] o, input logic [15:0] r, input logic [15:0] s,
                       input logic [2:0] d);
    start = 1'b1; op = o; r_in = r; s_in = s; dst_adr = d;
    @(negedge clock);
  endtask

  task automatic idle();
    start = 1'b0;
    op = 3'($urandom); r_in = 16'($urandom); s_in = 16'($urandom); dst_adr = 3'($urandom);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (we === 1'b1) begin
        wr_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_we: got w=%h adr=%0d with no write expected", w, w_adr);
        end else begin
          e = sb.pop_front();
          if (w !== e.w || w_adr !== e.adr || zero !== e.z || carry !== e.c) begin
            errors++;
            $display("FAIL write: got w=%h adr=%0d z=%b c=%b expected w=%h adr=%0d z=%b c=%b",
                     w, w_adr, zero, carry, e.w, e.adr, e.z, e.c);
          end
        end
      end
    end
  end

  initial begin
    // reset with random inputs
    repeat (2) begin
      start = 1'($urandom); op = 3'($urandom); r_in = 16'($urandom);
      s_in = 16'($urandom); dst_adr = 3'($urandom);
      @(negedge clock);
    end
    chk("rst_w", w, 16'h0000);
    chk("rst_adr", {13'h0, w_adr}, 16'h0000);
    chk("rst_we", {15'h0, we}, 16'h0000);
    chk("rst_busy", {15'h0, busy}, 16'h0000);
    chk("rst_flags", {14'h0, zero, carry}, 16'h0000);
    reset = 1'b0;
    idle();
    repeat (4) begin @(negedge clock); idle(); end

    // ADD with carry out and zero result
    push(16'h0000, 3'd3, 1'b1, 1'b1);
    drive(3'b000, 16'hFFFF, 16'h0001, 3'd3);
    idle();
    repeat (2) @(negedge clock);

    // back-to-back: SUB borrow, XOR, AND, OR
    push(16'hFFFE, 3'd1, 1'b0, 1'b1);
    drive(3'b001, 16'h0005, 16'h0007, 3'd1);
    push(16'h0F00, 3'd2, 1'b0, 1'b0);
    drive(3'b100, 16'h00F0, 16'h0FF0, 3'd2);
    push(16'h00F0, 3'd0, 1'b0, 1'b0);
    drive(3'b010, 16'hF0F0, 16'h0FF0, 3'd0);
    push(16'hF00F, 3'd7, 1'b0, 1'b0);
    drive(3'b011, 16'hF000, 16'h000F, 3'd7);
    idle();
    repeat (2) @(negedge clock);

    // shifts; only s[3:0] is the amount
    push(16'h0002, 3'd4, 1'b0, 1'b0);
    drive(3'b101, 16'h8001, 16'h0011, 3'd4);
    push(16'h0001, 3'd6, 1'b0, 1'b0);
    drive(3'b110, 16'h8000, 16'h000F, 3'd6);
    idle();
    repeat (2) begin @(negedge clock); idle(); end
    chk("hold_w", w, 16'h0001);
    chk("hold_adr", {13'h0, w_adr}, 16'h0006);
    chk("hold_we", {15'h0, we}, 16'h0000);

    // MUL latency
    push(16'h1230, 3'd5, 1'b0, 1'b0);
    drive(3'b111, 16'h0123, 16'h0010, 3'd5);
    idle();
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("mul_busy_%0d", i), {15'h0, busy}, 16'h0001);
      chk($sformatf("mul_nowe_%0d", i), {15'h0, we}, 16'h0000);
      @(negedge clock);
    end
    chk("mul_busy_done", {15'h0, busy}, 16'h0000);
    chk("mul_we", {15'h0, we}, 16'h0001);
    @(negedge clock);

    // MUL overflow: low half zero, high half non-zero
    push(16'h0000, 3'd7, 1'b1, 1'b1);
    drive(3'b111, 16'h1000, 16'h0100, 3'd7);
    idle();
    repeat (20) @(negedge clock);

    // start while busy is dropped
    push(16'h000F, 3'd2, 1'b0, 1'b0);
    drive(3'b111, 16'h0003, 16'h0005, 3'd2);
    idle();
    repeat (3) @(negedge clock);
    drive(3'b000, 16'h0001, 16'h0001, 3'd3);
    idle();
    repeat (20) @(negedge clock);
    chk("ign_wcount", 16'(wr_cnt), 16'(exp_cnt));

    // reset mid-multiply aborts with no write
    drive(3'b111, 16'h7777, 16'h3333, 3'd1);
    idle();
    repeat (5) @(negedge clock);
    chk("abort_busy_pre", {15'h0, busy}, 16'h0001);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_w", w, 16'h0000);
    chk("abort_adr", {13'h0, w_adr}, 16'h0000);
    chk("abort_busy", {15'h0, busy}, 16'h0000);
    chk("abort_flags", {14'h0, zero, carry}, 16'h0000);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("abort_wcount", 16'(wr_cnt), 16'(exp_cnt));

    push(16'h2345, 3'd4, 1'b0, 1'b0);
    drive(3'b000, 16'h1234, 16'h1111, 3'd4);
    idle();
    repeat (4) @(negedge clock);

    chk("sb_empty", 16'(sb.size()), 16'h0000);
    chk("final_wcount", 16'(wr_cnt), 16'(exp_cnt));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
